// File: rtl/ocimem_access_arbiter.sv
// Arbiter for the single-port OCI debug RAM, shared by the CPU (Avalon) path and
// the JTAG debug slave's decoded actions.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no access in progress; arbitrate CPU vs pending JTAG
// CPU_ACC  | RAM strobe for the CPU; a write completes here
// CPU_RD   | registered RAM read data returned to the CPU
// JTAG_ACC | RAM strobe at the JTAG pointer; a write completes here
// JTAG_RD  | registered RAM read data captured into mon_dreg
module ocimem_access_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DW-1:0]     cpu_writedata,
  input  logic [DW/8-1:0]   cpu_byteenable,
  output logic              cpu_waitrequest,
  output logic [DW-1:0]     cpu_readdata,
  input  logic              jtag_ld_addr,
  input  logic [AW-1:0]     jtag_addr,
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic [DW-1:0]     jtag_wdata,
  output logic [DW-1:0]     mon_dreg,
  output logic              mon_ready,
  output logic              jtag_overrun,
  input  logic              jtag_overrun_clr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic [DW/8-1:0]   ram_be,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CPU_ACC  = 3'd1,
    CPU_RD   = 3'd2,
    JTAG_ACC = 3'd3,
    JTAG_RD  = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            last_grant_jtag;
  logic [AW-1:0]   ptr;
  logic            pending;
  logic            pend_wr;
  logic [DW-1:0]   pend_wdata;
  logic [DW-1:0]   readdata_q;
  logic            cpu_req;
  logic            jtag_done;

  assign cpu_req = cpu_read | cpu_write;

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and RAM/CPU strobes. A CPU read+write collision is a write.
  always_comb begin
    state_nxt       = state;
    ram_en          = 1'b0;
    ram_we          = 1'b0;
    ram_addr        = '0;
    ram_be          = '0;
    ram_wdata       = '0;
    cpu_waitrequest = 1'b1;
    cpu_readdata    = readdata_q;
    jtag_done       = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req && (!pending || last_grant_jtag)) state_nxt = CPU_ACC;
        else if (pending)                              state_nxt = JTAG_ACC;
      end
      CPU_ACC: begin
        ram_en   = 1'b1;
        ram_addr = cpu_address;
        ram_be   = cpu_byteenable;
        if (cpu_write) begin
          ram_we          = 1'b1;
          ram_wdata       = cpu_writedata;
          cpu_waitrequest = 1'b0;
          state_nxt       = IDLE;
        end else begin
          state_nxt = CPU_RD;
        end
      end
      CPU_RD: begin
        cpu_readdata    = ram_rdata;
        cpu_waitrequest = 1'b0;
        state_nxt       = IDLE;
      end
      JTAG_ACC: begin
        ram_en   = 1'b1;
        ram_addr = ptr;
        ram_be   = '1;
        if (pend_wr) begin
          ram_we    = 1'b1;
          ram_wdata = pend_wdata;
          jtag_done = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = JTAG_RD;
        end
      end
      JTAG_RD: begin
        jtag_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Round-robin memory: remember who was granted on each IDLE exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_jtag <= 1'b1;
    end else if (state == IDLE) begin
      if (state_nxt == CPU_ACC)       last_grant_jtag <= 1'b0;
      else if (state_nxt == JTAG_ACC) last_grant_jtag <= 1'b1;
    end
  end

  // Hold CPU read data after the completing cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 readdata_q <= '0;
    else if (state == CPU_RD)  readdata_q <= ram_rdata;
  end

  // JTAG command slot: a load or request is only taken while nothing is pending,
  // so the pointer load and the post-access increment never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      pending    <= 1'b0;
      pend_wr    <= 1'b0;
      pend_wdata <= '0;
      mon_ready  <= 1'b1;
    end else if (!pending) begin
      if (jtag_ld_addr) ptr <= jtag_addr;
      if (jtag_req) begin
        pending    <= 1'b1;
        pend_wr    <= jtag_wr;
        pend_wdata <= jtag_wdata;
        mon_ready  <= 1'b0;
      end
    end else if (jtag_done) begin
      pending   <= 1'b0;
      mon_ready <= 1'b1;
      ptr       <= ptr + AW'(1);
    end
  end

  // Capture JTAG read data for the monitor data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  mon_dreg <= '0;
    else if (state == JTAG_RD)  mon_dreg <= ram_rdata;
  end

  // Sticky overrun flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) jtag_overrun <= 1'b0;
    else       jtag_overrun <= (pending & (jtag_req | jtag_ld_addr)) |
                               (jtag_overrun & ~jtag_overrun_clr);
  end

endmodule

// File: doc/ocimem_access_arbiter.md
Name: ocimem_access_arbiter

Overview:
- Arbitrates one single-port on-chip debug RAM between two requesters.
- The CPU requester is the Avalon debug memory slave path, with waitrequest-based flow control.
- The JTAG requester is the debug slave's sysclk-side decoded actions: address load and data access pulses, with JTAG auto-incrementing address.
- Sits between the debug slave wrapper outputs, the CPU debug slave port and the OCI RAM. It sequences every RAM access and returns JTAG read data to the monitor data register.

Parameters:
- AW, 8, RAM word-address width; depth is 2^AW words.
- DW, 32, data width; byte enables are DW/8 bits wide.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_address  in  AW  CPU word address
- cpu_read  in  1  CPU read request, held until waitrequest is low
- cpu_write  in  1  CPU write request, held until waitrequest is low
- cpu_writedata  in  DW  CPU write data
- cpu_byteenable  in  DW/8  CPU byte enables
- cpu_waitrequest  out  1  stall; low for exactly the completing cycle
- cpu_readdata  out  DW  read data, valid while waitrequest is low on a read
- jtag_ld_addr  in  1  pulse: load the JTAG address pointer from jtag_addr
- jtag_addr  in  AW  new JTAG address
- jtag_req  in  1  pulse: request one JTAG access at the pointer
- jtag_wr  in  1  qualifies jtag_req: 1 = write, 0 = read
- jtag_wdata  in  DW  JTAG write data; full-word write
- mon_dreg  out  DW  last JTAG read data
- mon_ready  out  1  JTAG access complete
- jtag_overrun  out  1  sticky: a JTAG command was dropped
- jtag_overrun_clr  in  1  clears jtag_overrun
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_be  out  DW/8  RAM byte enables
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data; registered, valid the cycle after ram_en with ram_we=0

Behaviour:
- Reset values:
  - State IDLE.
  - cpu_waitrequest=1, cpu_readdata=0.
  - mon_dreg=0, mon_ready=1, jtag_overrun=0.
  - JTAG pointer=0, jtag pending=0, last_grant=JTAG, so the CPU wins the first conflict.
  - ram_en=0, ram_we=0.
- cpu_waitrequest is 1 in every cycle except the completing cycle of a CPU access.
- JTAG command capture:
  - jtag_req sets a one-entry pending flag, latches jtag_wr and jtag_wdata, and clears mon_ready.
  - jtag_ld_addr loads the pointer.
  - jtag_ld_addr and jtag_req in the same cycle: the load applies first, and the access uses the new address.
  - A jtag_req or jtag_ld_addr arriving while pending=1 or a JTAG access is in flight is dropped and sets jtag_overrun.
  - jtag_overrun_clr clears jtag_overrun. A set and a clear in the same cycle resolve to set.
- FSM states: IDLE, CPU_ACC, CPU_RD, JTAG_ACC, JTAG_RD.
- IDLE:
  - CPU request only goes to CPU_ACC.
  - Pending JTAG only goes to JTAG_ACC.
  - Both: grant the requester that is not last_grant (round-robin).
  - last_grant updates on entry to each ACC state.
- CPU_ACC:
  - ram_en=1, ram_addr=cpu_address, ram_be=cpu_byteenable.
  - On a write: ram_we=1 and ram_wdata=cpu_writedata; cpu_waitrequest=0 this cycle; return to IDLE.
  - On a read: go to CPU_RD.
- CPU_RD: cpu_readdata=ram_rdata (registered into cpu_readdata during this cycle's output), cpu_waitrequest=0, return to IDLE.
- CPU latency from request seen in IDLE: write completes 2nd cycle, read completes 3rd cycle.
- JTAG_ACC:
  - ram_en=1, ram_addr=pointer, ram_be all ones.
  - On a write: ram_we=1 and ram_wdata=latched data; set mon_ready, clear pending, increment the pointer, return to IDLE.
  - On a read: go to JTAG_RD.
- JTAG_RD: mon_dreg<=ram_rdata, mon_ready<=1, clear pending, increment the pointer, return to IDLE.
- Pointer increment wraps from 2^AW-1 to 0.
- cpu_read and cpu_write both high is illegal; treat it as a write.
- CPU request deassertion while waitrequest=1 is an Avalon protocol violation and is not supported.
- No IDLE bubble removal: back-to-back accesses always pass through IDLE. Throughput is 1 write per 2 cycles and 1 read per 3 cycles per requester.
- Reset asserted mid-access aborts immediately: ram_en=0 asynchronously and all state returns to reset values. A dropped JTAG access leaves mon_ready=1 and the pointer at 0.

Test Plan:
- CPU-only traffic:
  - Write 0xDEADBEEF to address 0x10 with be=4'b0011 -> waitrequest low on the 2nd cycle; ram_we=1, ram_be=0011.
  - Read 0x10 -> cpu_readdata=0x0000BEEF on the 3rd cycle.
- JTAG auto-increment:
  - Load address 0xFE, then issue 3 writes of 1, 2, 3 -> RAM[0xFE]=1, RAM[0xFF]=2, RAM[0x00]=3 (wrap).
  - Reload 0xFE and issue 3 reads -> mon_dreg sequence 1, 2, 3; mon_ready low for exactly the in-flight duration of each.
- Conflict:
  - CPU read and jtag_req arrive in the same cycle right after reset -> CPU granted first, then JTAG.
  - Repeat while both stay continuously active -> grants alternate CPU/JTAG/CPU/JTAG.
- Overrun:
  - A second jtag_req one cycle after the first -> exactly one RAM access, jtag_overrun=1.
  - jtag_overrun_clr -> jtag_overrun=0.
  - jtag_overrun_clr in the same cycle as a new drop -> jtag_overrun stays 1.
- Simultaneous load and request: jtag_ld_addr=0x40 together with a jtag_req read -> ram_addr=0x40 in JTAG_ACC; pointer=0x41 afterward.
- Reset mid-read: assert reset in CPU_RD -> next edge shows cpu_waitrequest=1, ram_en=0, mon_ready=1, pointer=0, jtag_overrun=0.
